// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer delay controller.
package reaction_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRwait,
    StWait5
  } delay_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int unsigned RAND_BITS = 12;

  // Right-shifting Galois step, taps 16,14,13,11; never reaches zero from a non-zero seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe generator. Build macro REACTION_FASTSIM_EN replaces the
// prescaler with a strobe on every cycle after reset.
module ms_tick_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_ms
);

`ifdef REACTION_FASTSIM_EN

  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign tick_ms = run_q;

`else

  localparam int unsigned Div = CLK_HZ / TICK_HZ;
  localparam int unsigned PrescW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [PrescW-1:0] PrescTerm = PrescW'(Div - 1);

  logic [PrescW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = (presc_q == PrescTerm) ? '0 : presc_q + PrescW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_ms = (presc_q == PrescTerm);

`endif

endmodule

// File: rtl/reaction_delay_ctrl.sv
// Shared ms wait counter for the reaction game plus the reaction-elapsed watchdog.
// Define REACTION_FASTSIM_EN to make every ms value count clock cycles.
module reaction_delay_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned RWAIT_MIN_MS = 1000,
  parameter int unsigned WAIT5_MS     = 5000,
  parameter int unsigned LATE_MS      = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_rwait,
  input  logic start_wait5,
  input  logic cancel,
  input  logic time_en,
  input  logic time_clr,
  output logic rwait_done,
  output logic wait5_done,
  output logic time_late,
  output logic tick_ms,
  output logic busy
);

  delay_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             rdone_q, rdone_d;
  logic             wdone_q, wdone_d;
  logic             late_q, late_d;
  logic             tick;

  ms_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_ms(tick)
  );

  assign lfsr_d = lfsr_next(lfsr_q);

  // Requests preempt whatever is running; expiry only wins when no request arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdone_d = 1'b0;
    wdone_d = 1'b0;
    if (cancel) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (start_wait5) begin
      state_d = StWait5;
      cnt_d   = CNT_W'(WAIT5_MS);
    end else if (start_rwait) begin
      state_d = StRwait;
      cnt_d   = CNT_W'(RWAIT_MIN_MS) + CNT_W'(lfsr_q[RAND_BITS-1:0]);
    end else if (state_q != StIdle && tick) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = StIdle;
        rdone_d = (state_q == StRwait);
        wdone_d = (state_q == StWait5);
      end
    end
  end

  always_comb begin
    elapsed_d = elapsed_q;
    if (time_clr) begin
      elapsed_d = '0;
    end else if (time_en && tick && (elapsed_q < CNT_W'(LATE_MS))) begin
      elapsed_d = elapsed_q + CNT_W'(1);
    end
    late_d = (elapsed_d >= CNT_W'(LATE_MS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      elapsed_q <= '0;
      lfsr_q    <= LFSR_SEED;
      rdone_q   <= 1'b0;
      wdone_q   <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      lfsr_q    <= lfsr_d;
      rdone_q   <= rdone_d;
      wdone_q   <= wdone_d;
      late_q    <= late_d;
    end
  end

  assign rwait_done = rdone_q;
  assign wait5_done = wdone_q;
  assign time_late  = late_q;
  assign tick_ms    = tick;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_reaction_delay_ctrl.sv
// Self-checking bench for reaction_delay_ctrl against an edge-indexed arithmetic model.
module tb_reaction_delay_ctrl;

  localparam int unsigned ClkHz = 1000;
  localparam int unsigned TickHz = 100;
  localparam int unsigned RMin = 4;
  localparam int unsigned W5 = 5;
  localparam int unsigned Late = 10;
  localparam int unsigned Div = ClkHz / TickHz;
`ifdef REACTION_FASTSIM_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_rwait = 1'b0, start_wait5 = 1'b0, cancel = 1'b0;
  logic time_en = 1'b0, time_clr = 1'b0;
  logic rwait_done, wait5_done, time_late, tick_ms, busy;

  always #5 clk = ~clk;

  reaction_delay_ctrl #(
    .CLK_HZ      (ClkHz),
    .TICK_HZ     (TickHz),
    .RWAIT_MIN_MS(RMin),
    .WAIT5_MS    (W5),
    .LATE_MS     (Late),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_rwait(start_rwait),
    .start_wait5(start_wait5),
    .cancel     (cancel),
    .time_en    (time_en),
    .time_clr   (time_clr),
    .rwait_done (rwait_done),
    .wait5_done (wait5_done),
    .time_late  (time_late),
    .tick_ms    (tick_ms),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Model: edges counted from reset release; a wait is (kind, edge of its last tick).
  int edge_n;
  int kind;        // 0 none, 1 random wait, 2 fixed wait
  int done_edge;
  int elapsed_m;
  int last_r;
  logic [15:0] lfsr_m;
  bit exp_r, exp_w;

  function automatic bit tick_at(input int e);
    if (Fast) return (e >= 2);
    return ((e % Div) == 0);
  endfunction

  // Edge on which the nt-th tick after a load at edge e lands.
  function automatic int nth_tick(input int e, input int nt);
    int first;
    if (Fast) first = (e + 1 < 2) ? 2 : e + 1;
    else first = ((e / Div) + 1) * Div;
    return first + (nt - 1) * (Fast ? 1 : Div);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    kind = 0;
    done_edge = 0;
    elapsed_m = 0;
    lfsr_m = 16'hACE1;
    exp_r = 1'b0;
    exp_w = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    exp_r = 1'b0;
    exp_w = 1'b0;
    if (cancel) begin
      kind = 0;
    end else if (start_wait5) begin
      kind = 2;
      done_edge = nth_tick(edge_n, W5);
    end else if (start_rwait) begin
      last_r = int'(lfsr_m[11:0]);
      kind = 1;
      done_edge = nth_tick(edge_n, RMin + last_r);
    end else if (kind != 0 && edge_n == done_edge) begin
      exp_r = (kind == 1);
      exp_w = (kind == 2);
      kind = 0;
    end
    if (time_clr) elapsed_m = 0;
    else if (time_en && tick_at(edge_n) && elapsed_m < Late) elapsed_m++;
    lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    @(negedge clk);
    chk("rwait_done", rwait_done, exp_r);
    chk("wait5_done", wait5_done, exp_w);
    chk("busy", busy, kind != 0);
    chk("tick_ms", tick_ms, tick_at(edge_n + 1));
    chk("time_late", time_late, elapsed_m >= Late);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (kind != 0 && c < budget) begin
      step();
      c++;
    end
    chk("wait_bound", kind == 0, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rwait_done"}, rwait_done, 1'b0);
    chk({tag, "_wait5_done"}, wait5_done, 1'b0);
    chk({tag, "_time_late"}, time_late, 1'b0);
    chk({tag, "_tick_ms"}, tick_ms, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int tcount;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Fixed wait from idle.
    idle(3);
    start_wait5 = 1'b1;
    step();
    start_wait5 = 1'b0;
    chk("t1_busy_from_load", busy, 1'b1);
    wait_idle(400);

    // Random waits; press timing chosen so the random part stays short.
    for (int rep = 0; rep < 3; rep++) begin
      idle($urandom_range(1, 60));
      c = 0;
      while (lfsr_m[11:0] >= 12'd256 && c < 5000) begin
        step();
        c++;
      end
      start_rwait = 1'b1;
      step();
      start_rwait = 1'b0;
      wait_idle(5000);
    end

    // Fixed wait preempts a random wait two cycles in.
    idle($urandom_range(1, 20));
    start_rwait = 1'b1;
    step();
    start_rwait = 1'b0;
    idle(1);
    start_wait5 = 1'b1;
    step();
    start_wait5 = 1'b0;
    wait_idle(400);

    // Both requests on one edge.
    start_rwait = 1'b1;
    start_wait5 = 1'b1;
    step();
    start_rwait = 1'b0;
    start_wait5 = 1'b0;
    chk("t3_both_busy", busy, 1'b1);
    wait_idle(400);

    // Restart on the expiry edge suppresses the done pulse.
    start_wait5 = 1'b1;
    step();
    start_wait5 = 1'b0;
    c = 0;
    while (edge_n + 1 != done_edge && c < 400) begin
      step();
      c++;
    end
    start_wait5 = 1'b1;
    step();
    start_wait5 = 1'b0;
    chk("t3_restart_no_done", wait5_done, 1'b0);
    wait_idle(400);

    // Cancel mid random wait, then cancel racing a start.
    start_rwait = 1'b1;
    step();
    start_rwait = 1'b0;
    idle(5);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("t4_cancel_busy", busy, 1'b0);
    idle(25);
    cancel = 1'b1;
    start_wait5 = 1'b1;
    step();
    cancel = 1'b0;
    start_wait5 = 1'b0;
    chk("t4_cancel_beats_start", busy, 1'b0);
    idle(3);

    // Elapsed watchdog.
    time_en = 1'b1;
    c = 0;
    while (elapsed_m < 9 && c < 200) begin
      step();
      c++;
    end
    chk("t5_late_at_9", time_late, 1'b0);
    while (elapsed_m < 10 && c < 300) begin
      step();
      c++;
    end
    chk("t5_late_at_10", time_late, 1'b1);
    time_en = 1'b0;
    idle(15);
    chk("t5_late_holds", time_late, 1'b1);
    time_clr = 1'b1;
    step();
    time_clr = 1'b0;
    chk("t5_clr", time_late, 1'b0);
    time_clr = 1'b1;
    time_en = 1'b1;
    idle(25);
    time_clr = 1'b0;
    time_en = 1'b0;
    step();
    chk("t5_clr_with_en", time_late, 1'b0);

    // Tick period.
    tcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      tcount += int'(tick_ms);
    end
    chk("t6_tick_count", tcount, Fast ? 40 : 40 / Div);

    // Asynchronous reset in the middle of a fixed wait.
    start_wait5 = 1'b1;
    step();
    start_wait5 = 1'b0;
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_delay_ctrl.md
Name: reaction_delay_ctrl

Overview:
- Timing controller for the reaction-timer game.
- Owns one shared millisecond down-counter and grants it to two requesters from reaction_fsm: the random pre-stimulus wait (start_rwait) and the fixed 5 s display wait (start_wait5).
- Returns one-cycle done pulses to reaction_fsm.
- Also runs the reaction-elapsed watchdog that raises time_late, and exports the 1 ms tick used by the reaction stopwatch.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1000, tick rate; one tick = 1 ms. CLK_HZ/TICK_HZ must be an integer ≥ 2.
- RWAIT_MIN_MS, 1000, minimum random wait. Must be ≥ 1.
- WAIT5_MS, 5000, fixed wait length. Must be ≥ 1.
- LATE_MS, 1000, reaction time at which time_late asserts.
- CNT_W, 16, width of the wait and elapsed counters. RWAIT_MIN_MS+4095 and WAIT5_MS must both be < 2**CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_rwait  in  1  request random wait (pulse from FSM)
- start_wait5  in  1  request fixed wait (pulse from FSM)
- cancel  in  1  abort any wait in progress
- time_en  in  1  reaction stopwatch running
- time_clr  in  1  clear elapsed counter
- rwait_done  out  1  one-cycle pulse, random wait expired
- wait5_done  out  1  one-cycle pulse, fixed wait expired
- time_late  out  1  level, elapsed ≥ LATE_MS
- tick_ms  out  1  one-cycle 1 ms strobe
- busy  out  1  shared counter granted (state ≠ IDLE)

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - All outputs are 0 in reset. State is IDLE, counters are 0, prescaler is 0, LFSR = 16'hACE1.
- Prescaler:
  - Free-running 0..CLK_HZ/TICK_HZ-1.
  - tick_ms is high for the single cycle when the prescaler equals its terminal value.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11 (mask 16'hB400). Advances every clock, never zero.
  - Randomness comes from user press timing.
- State machine: IDLE, RWAIT, WAIT5.
- Request priority, evaluated each edge:
  - cancel has highest priority: go to IDLE, counter = 0, no done pulse.
  - Else start_wait5: counter = WAIT5_MS, go to WAIT5.
  - Else start_rwait: counter = RWAIT_MIN_MS + lfsr[11:0] (value sampled that edge), go to RWAIT.
  - A start in any state, including while busy, preempts. The aborted wait produces no done pulse.
  - start_wait5 and start_rwait together: wait5 wins.
- Counting:
  - In RWAIT/WAIT5, counter decrements on each tick_ms edge.
  - On the edge where counter goes 1→0:
    - Next state is IDLE.
    - The matching done is registered high for exactly the following cycle.
  - A load value of N produces done after exactly N ticks. Latency jitter vs wall time is < 1 tick, due to the partial first tick.
- Simultaneous events: a start on the same edge as expiry cancels the done pulse; the new wait loads.
- Elapsed watchdog:
  - time_clr has priority: elapsed = 0.
  - Else if time_en and tick_ms: elapsed increments, saturating at LATE_MS.
  - time_late = (elapsed ≥ LATE_MS), registered.
  - time_late stays high until time_clr or reset. It is independent of the wait state machine.
- rwait_done and wait5_done are never high together.

Optional Feature:
- REACTION_FASTSIM_EN.
- Defined: prescaler removed, tick_ms = 1 every cycle after reset, so all ms values count clocks (simulation use).
- Undefined: normal prescaled tick.
- Ports and all other behaviour are identical in both builds.

Decomposition:
- Package reaction_pkg:
  - delay_state_t enum (IDLE, RWAIT, WAIT5).
  - LFSR_SEED = 16'hACE1, LFSR_MASK = 16'hB400.
  - RAND_BITS = 12.
- Sub-module ms_tick_gen: parameterised prescaler producing tick_ms. Holds the REACTION_FASTSIM_EN bypass.

Test Plan:
1. FASTSIM, WAIT5_MS=5. rst_n low 3 cycles then high → all outputs 0, busy 0. start_wait5 pulse at edge E → busy from E, wait5_done high exactly in cycle after edge E+5, busy 0 afterwards.
2. FASTSIM, RWAIT_MIN_MS=4. start_rwait at edge E, bench LFSR model gives lfsr[11:0]=R → rwait_done after edge E+4+R. Repeat 3 times with differing press timing → R values differ.
3. Preempt and priority:
   - start_rwait, then start_wait5 after 2 cycles → no rwait_done; wait5_done WAIT5_MS ticks after the second request.
   - start_rwait and start_wait5 on the same edge → WAIT5 chosen.
4. cancel mid-RWAIT → busy 0 next cycle, no done pulse for 20 cycles. cancel asserted with start_wait5 → stays IDLE.
5. FASTSIM, LATE_MS=10:
   - time_en high 9 cycles → time_late 0; 10th tick → time_late 1. Holds after time_en drops.
   - time_clr → 0 next cycle. time_clr with time_en high → elapsed stays 0.
6. rst_n asserted asynchronously mid-WAIT5 (between edges) → outputs 0 immediately, no done pulse after release. Normal build CLK_HZ=1000, TICK_HZ=100 → tick_ms period exactly 10 cycles.
